// File: rtl/avg3_pkg.sv
// Shared types and helpers for the 3-sample streaming averager.
package avg3_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        COLLECT,
        DIVIDE,
        OUTPUT
    } state_t;

    // Accumulator width that can hold ns samples of dw bits without overflow.
    function automatic int sum_w(input int dw, input int ns);
        return dw + $clog2(ns);
    endfunction

endpackage

// File: rtl/avg3_stream_collector_seq_div_const.sv
// Multi-cycle restoring divider by a constant: one quotient bit per cycle,
// MSB first, exactly SUM_W cycles from start to done.
module seq_div_const #(
    parameter int SUM_W   = 10,
    parameter int DIVISOR = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    output logic             done,
    output logic [SUM_W-1:0] quotient
);

    // The remainder is always below DIVISOR, so RW-1 bits hold it; the
    // shifted trial value needs one more.
    localparam int RW = $clog2(DIVISOR) + 1;
    localparam int CW = $clog2(SUM_W + 1);
    localparam logic [RW-1:0] DIV = RW'(DIVISOR);

    logic [RW-2:0] rem;
    logic [RW-1:0] rem_sh;
    logic [RW-2:0] rem_nxt;
    logic          q_bit;
    logic [CW-1:0] bit_cnt;
    logic          busy;

    // One restoring step: bring down the next dividend bit and trial-subtract.
    always_comb begin
        rem_sh  = {rem, quotient[SUM_W-1]};
        q_bit   = (rem_sh >= DIV);
        rem_nxt = q_bit ? (RW-1)'(rem_sh - DIV) : rem_sh[RW-2:0];
    end

    // Quotient register doubles as the dividend shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            quotient <= '0;
            bit_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem      <= '0;
                quotient <= dividend;
                bit_cnt  <= '0;
                busy     <= 1'b1;
            end else if (busy) begin
                rem      <= rem_nxt;
                quotient <= {quotient[SUM_W-2:0], q_bit};
                if (bit_cnt == CW'(SUM_W - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/avg3_stream_collector.sv
// Streaming averager: groups NSAMP input samples, divides the sum by NSAMP
// with a sequential divider and presents the result on a valid/ready port.
// Optional macro AVG3_ROUND_NEAREST_EN selects round-half-up instead of floor.
module avg3_stream_collector
    import avg3_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NSAMP  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    localparam int SUM_W = sum_w(DATA_W, NSAMP);
    localparam int CNT_W = $clog2(NSAMP);
    localparam logic [SUM_W-1:0] Q_MAX = SUM_W'((1 << DATA_W) - 1);

    state_t             state;
    logic [SUM_W-1:0]   sum;
    logic [SUM_W-1:0]   sum_nxt;
    logic [SUM_W-1:0]   dividend;
    logic [CNT_W-1:0]   count;
    logic               in_xfer;
    logic               last_xfer;
    logic               div_done;
    logic [SUM_W-1:0]   quot;
    logic [DATA_W-1:0]  quot_sat;

    assign in_ready  = (state == COLLECT);
    assign in_xfer   = in_valid && in_ready;
    assign last_xfer = in_xfer && (count == CNT_W'(NSAMP - 1));
    assign sum_nxt   = sum + SUM_W'(in_data);

`ifdef AVG3_ROUND_NEAREST_EN
    assign dividend = sum_nxt + SUM_W'(NSAMP / 2);
`else
    assign dividend = sum_nxt;
`endif

    // Floor quotients always fit; only the rounded form can need clamping.
    assign quot_sat = (quot > Q_MAX) ? '1 : quot[DATA_W-1:0];

    // Divider is launched on the edge that accepts the last sample of a group.
    seq_div_const #(
        .SUM_W   (SUM_W),
        .DIVISOR (NSAMP)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (last_xfer),
        .dividend (dividend),
        .done     (div_done),
        .quotient (quot)
    );

    // Control FSM with accumulator, sample counter and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= COLLECT;
            sum       <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (in_xfer) begin
                        sum <= sum_nxt;
                        if (last_xfer) begin
                            count <= '0;
                            state <= DIVIDE;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                DIVIDE: begin
                    if (div_done) begin
                        out_data  <= quot_sat;
                        out_valid <= 1'b1;
                        state     <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        sum       <= '0;
                        state     <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_avg3_stream_collector.sv
// Self-checking bench for avg3_stream_collector against a queue-based model.
module tb_avg3_stream_collector;
    import avg3_pkg::*;

    localparam int DW = 8;
    localparam int NS = 3;
    localparam int SW = sum_w(DW, NS);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int t_last = 0;
    int grp[$];
    int exp_q[$];

    avg3_stream_collector #(.DATA_W(DW), .NSAMP(NS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Average of a group straight from its arithmetic definition.
    function automatic int ref_avg(input int s);
        int d;
        d = s;
`ifdef AVG3_ROUND_NEAREST_EN
        d = s + NS / 2;
`endif
        d = d / NS;
        if (d > (1 << DW) - 1) d = (1 << DW) - 1;
        return d;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_data", int'(out_data), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        grp.delete();
        exp_q.delete();
    endtask

    // Offer one sample after 'gap' idle cycles; returns just after the accepting edge.
    task automatic send(input int v, input int gap);
        int k;
        int s;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = DW'(v);
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 200) begin @(negedge clk); k++; end
        if (!in_ready) begin
            check("send_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        t_last   = cyc;
        in_valid = 1'b0;
        grp.push_back(v);
        if (grp.size() == NS) begin
            s = 0;
            foreach (grp[i]) s += grp[i];
            exp_q.push_back(ref_avg(s));
            grp.delete();
        end
    endtask

    // Wait for a result, optionally check latency, stall 'hold' cycles, accept.
    task automatic recv(input int hold, input bit chk_lat);
        int k;
        int exp;
        int d0;
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 200) begin @(negedge clk); k++; end
        if (!out_valid) begin
            check("recv_timeout", 0, 1);
            return;
        end
        if (chk_lat) check("latency", cyc - t_last, SW + 1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        check("out_data", int'(out_data), exp);
        check("in_ready_output", int'(in_ready), 0);
        d0 = int'(out_data);
        repeat (hold) begin
            @(negedge clk);
            check("hold_valid", int'(out_valid), 1);
            check("hold_data", int'(out_data), d0);
            check("hold_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_valid", int'(out_valid), 0);
        check("post_in_ready", int'(in_ready), 1);
        check("post_data_held", int'(out_data), d0);
    endtask

    initial begin
        do_reset();

        // back-to-back group with latency check
        send(10, 0); send(20, 0); send(30, 0);
        recv(0, 1'b1);

        // extremes
        send(255, 0); send(255, 0); send(255, 0);
        recv(1, 1'b1);
        send(0, 0); send(0, 0); send(0, 0);
        recv(0, 1'b1);

        // rounding-sensitive groups
        send(1, 0); send(2, 0); send(2, 0);
        recv(0, 1'b1);
        send(1, 1); send(1, 0); send(2, 2);
        recv(0, 1'b1);

        // stalled output with a sample held on the input the whole time
        send(40, 0); send(50, 0); send(60, 0);
        in_valid = 1'b1;
        in_data  = 8'd99;
        recv(5, 1'b1);
        in_valid = 1'b0;
        send(1, 0); send(1, 0); send(2, 0);
        recv(0, 1'b1);

        // random input gaps across two groups
        send(3, $urandom_range(0, 3)); send(3, $urandom_range(0, 3)); send(3, $urandom_range(0, 3));
        recv($urandom_range(0, 2), 1'b1);
        send(6, $urandom_range(0, 3)); send(7, $urandom_range(0, 3)); send(8, $urandom_range(0, 3));
        recv($urandom_range(0, 2), 1'b1);

        // reset mid-divide, then after a partial group
        send(90, 0); send(91, 0); send(92, 0);
        repeat (4) begin @(posedge clk); #1; end
        do_reset();
        send(100, 0); send(200, 0);
        do_reset();
        send(4, 0); send(5, 0); send(6, 0);
        recv(0, 1'b1);

        // randomized groups
        for (int g = 0; g < 25; g++) begin
            for (int j = 0; j < NS; j++) send($urandom_range(0, 255), $urandom_range(0, 3));
            recv($urandom_range(0, 3), 1'b1);
        end

        check("model_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
